// File: rtl/mxv_stream_engine_pkg.sv
// mxv_stream_engine_pkg: shared defaults and FSM state type for the MxV stream engine
package mxv_stream_engine_pkg;
    localparam int MXV_DW    = 8;
    localparam int MXV_MAX_N = 8;
    typedef enum logic [2:0] {IDLE, LOAD_MAT, LOAD_VEC, COMPUTE, EMIT} mxv_state_t;
endpackage

// File: rtl/mxv_mat_ram.sv
// mxv_mat_ram: MAX_N*MAX_N x DW matrix store, synchronous write, asynchronous read
//   clk     in  clock
//   we_i    in  write enable
//   addr_i  in  shared read/write address r*MAX_N+c
//   wdata_i in  write data
//   rdata_o out read data for addr_i
module mxv_mat_ram #(
    parameter int DW    = 8,
    parameter int MAX_N = 8,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o
);
    logic [DW-1:0] mem_q [MAX_N*MAX_N];
    always_ff @(posedge clk) begin
        if (we_i) mem_q[addr_i] <= wdata_i;
    end
    assign rdata_o = mem_q[addr_i];
endmodule

// File: rtl/mxv_stream_engine.sv
// mxv_stream_engine: loads an NxN matrix and N-vector over a byte stream, then streams out N dot products
//   clk, rst            clock, synchronous active-high reset
//   start, cfg_n        run request and matrix size (sampled in IDLE)
//   in_valid/in_data/in_ready     element input stream (matrix row-major, then vector)
//   out_valid/out_data/out_last/out_ready  result stream, out_last on the final row
//   busy, err           not-idle flag, one-cycle pulse on a rejected start
module mxv_stream_engine
    import mxv_stream_engine_pkg::*;
#(
    parameter int DW    = MXV_DW,
    parameter int MAX_N = MXV_MAX_N,
    parameter int NW    = $clog2(MAX_N + 1),
    parameter int ACC_W = 2 * DW + $clog2(MAX_N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [NW-1:0]    cfg_n,
    input  logic             in_valid,
    input  logic [DW-1:0]    in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [ACC_W-1:0] out_data,
    output logic             out_last,
    input  logic             out_ready,
    output logic             busy,
    output logic             err
);
    localparam int IW = (MAX_N > 1) ? $clog2(MAX_N) : 1;
    localparam int AW = (MAX_N > 1) ? $clog2(MAX_N * MAX_N) : 1;
    localparam logic [NW-1:0] N_ONE = 1;
    localparam logic [IW-1:0] I_ONE = 1;

    mxv_state_t state_q, state_d;
    logic [IW-1:0] nm1_q, nm1_d, r_q, r_d, c_q, c_d;
    logic [ACC_W-1:0] acc_q, acc_d, out_data_q, out_data_d;
    logic out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic in_ready_q, in_ready_d, err_q, err_d;
    logic [DW-1:0] v_q [MAX_N];
    logic [DW-1:0] m_rd;
    logic [AW-1:0] addr;
    logic [ACC_W-1:0] acc_sum;
    logic hs_in, last_c, last_r, cfg_ok, m_we;

    assign hs_in   = in_valid & in_ready_q;
    assign last_c  = c_q == nm1_q;
    assign last_r  = r_q == nm1_q;
    assign cfg_ok  = (cfg_n != '0) && (cfg_n <= NW'(MAX_N));
    assign addr    = AW'(r_q) * AW'(MAX_N) + AW'(c_q);
    assign acc_sum = acc_q + ACC_W'(m_rd) * ACC_W'(v_q[c_q]);
    assign m_we    = !rst && state_q == LOAD_MAT && hs_in;

    mxv_mat_ram #(.DW(DW), .MAX_N(MAX_N), .AW(AW)) u_ram (
        .clk    (clk),
        .we_i   (m_we),
        .addr_i (addr),
        .wdata_i(in_data),
        .rdata_o(m_rd)
    );

    always_comb begin
        state_d     = state_q;
        nm1_d       = nm1_q;
        r_d         = r_q;
        c_d         = c_q;
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        err_d       = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                err_d = !cfg_ok;
                if (cfg_ok) begin
                    nm1_d   = IW'(cfg_n - N_ONE);
                    r_d     = '0;
                    c_d     = '0;
                    state_d = LOAD_MAT;
                end
            end
            LOAD_MAT: if (hs_in) begin
                c_d = last_c ? '0 : c_q + I_ONE;
                r_d = !last_c ? r_q : last_r ? '0 : r_q + I_ONE;
                state_d = (last_c && last_r) ? LOAD_VEC : LOAD_MAT;
            end
            LOAD_VEC: if (hs_in) begin
                c_d     = last_c ? '0 : c_q + I_ONE;
                acc_d   = '0;
                state_d = last_c ? COMPUTE : LOAD_VEC;
            end
            COMPUTE: begin
                acc_d = acc_sum;
                c_d   = c_q + I_ONE;
                if (last_c) begin
                    out_data_d  = acc_sum;
                    out_valid_d = 1'b1;
                    out_last_d  = last_r;
                    state_d     = EMIT;
                end
            end
            EMIT: if (out_ready) begin
                out_valid_d = 1'b0;
                acc_d       = '0;
                c_d         = '0;
                r_d         = out_last_q ? r_q : r_q + I_ONE;
                state_d     = out_last_q ? IDLE : COMPUTE;
            end
            default: state_d = IDLE;
        endcase
        in_ready_d = state_d == LOAD_MAT || state_d == LOAD_VEC;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            nm1_q       <= '0;
            r_q         <= '0;
            c_q         <= '0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            in_ready_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            nm1_q       <= nm1_d;
            r_q         <= r_d;
            c_q         <= c_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            in_ready_q  <= in_ready_d;
            err_q       <= err_d;
        end
    end

    // Vector storage is intentionally not reset; every entry read is written in the same run.
    always_ff @(posedge clk) begin
        if (!rst && state_q == LOAD_VEC && hs_in) v_q[c_q] <= in_data;
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign busy      = state_q != IDLE;
    assign err       = err_q;
endmodule

// File: tb/tb_mxv_stream_engine.sv
// tb_mxv_stream_engine: directed bench with a dot-product reference model and per-cycle output checker
module tb_mxv_stream_engine;
    logic        clk = 0;
    logic        rst = 1;
    logic        start = 0;
    logic [3:0]  cfg_n = 0;
    logic        in_valid = 0;
    logic [7:0]  in_data = 0;
    logic        in_ready;
    logic        out_valid;
    logic [18:0] out_data;
    logic        out_last;
    logic        out_ready = 1;
    logic        busy;
    logic        err;

    typedef struct { logic [31:0] d; bit l; } exp_t;
    exp_t exp_q[$];
    logic [31:0] got_d[$];
    bit got_l[$];
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit prev_v = 0, prev_r = 0;
    logic [18:0] prev_d = 0;

    mxv_stream_engine dut (
        .clk(clk), .rst(rst), .start(start), .cfg_n(cfg_n),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .out_ready(out_ready), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_v = 0;
            prev_r = 0;
        end else begin
            if (prev_v && !prev_r) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, prev_d);
            end
            if (out_valid) begin
                if (exp_q.size() == 0) chk("spurious_out", out_valid, 0);
                else begin
                    chk("out_data", out_data, exp_q[0].d);
                    chk("out_last", out_last, exp_q[0].l);
                    if (out_ready) begin
                        got_d.push_back(out_data);
                        got_l.push_back(out_last);
                        void'(exp_q.pop_front());
                    end
                end
            end
            prev_v = out_valid;
            prev_r = out_ready;
            prev_d = out_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int d);
        bit ok;
        int t = 0;
        in_valid = 1;
        in_data = d[7:0];
        forever begin
            ok = in_ready;
            tick();
            if (ok) break;
            if (++t > 50) begin
                chk("in_timeout", in_ready, 1);
                break;
            end
        end
        in_valid = 0;
    endtask

    task automatic run(input int n, input int m[64], input int v[8], input bit gap,
                       input int stall_row, input bit poke);
        int t0, t1, t, stall_cnt;
        for (int r = 0; r < n; r++) begin
            int s = 0;
            for (int c = 0; c < n; c++) s += m[r*n+c] * v[c];
            exp_q.push_back('{d: s, l: (r == n-1)});
        end
        got_d.delete();
        got_l.delete();
        start = 1;
        cfg_n = n[3:0];
        tick();
        start = 0;
        t0 = cyc;
        chk("busy_after_start", busy, 1);
        chk("in_ready_after_start", in_ready, 1);
        for (int i = 0; i < n*n + n; i++) begin
            if (gap && i % 3 == 1) tick();
            if (poke && i == 2) begin start = 1; cfg_n = 0; end
            send(i < n*n ? m[i] : v[i-n*n]);
            if (poke && i == 2) begin
                start = 0;
                chk("start_ignored_err", err, 0);
                chk("start_ignored_busy", busy, 1);
            end
        end
        if (!gap) chk("load_cycles", cyc - t0, n*n + n);
        chk("in_ready_after_load", in_ready, 0);
        t1 = cyc;
        t = 0;
        stall_cnt = 0;
        while (exp_q.size() > 0 && t < 2000) begin
            out_ready = !((n - exp_q.size()) == stall_row && out_valid && stall_cnt < 4);
            if (!out_ready) stall_cnt++;
            tick();
            t++;
        end
        out_ready = 1;
        chk("all_results", exp_q.size(), 0);
        chk("busy_after_run", busy, 0);
        chk("out_cycles", cyc - t1, n*(n+1) + (stall_row >= 0 ? 4 : 0));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_out_last"}, out_last, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    int m[64];
    int v[8];

    task automatic run_n2();
        m = '{default: 0};
        v = '{default: 0};
        m[0] = 1; m[1] = 2; m[2] = 3; m[3] = 4;
        v[0] = 5; v[1] = 6;
        run(2, m, v, 0, -1, 0);
        chk("n2_r0", got_d[0], 17);
        chk("n2_r1", got_d[1], 39);
        chk("n2_l0", got_l[0], 0);
        chk("n2_l1", got_l[1], 1);
    endtask

    initial begin
        rst = 1;
        tick();
        tick();
        chk_reset_outputs("reset");
        rst = 0;
        tick();

        run_n2();

        m = '{default: 255};
        v = '{default: 255};
        run(8, m, v, 0, -1, 0);
        chk("n8_r0", got_d[0], 520200);
        chk("n8_r7", got_d[7], 520200);
        chk("n8_l7", got_l[7], 1);

        m = '{default: 0};
        v = '{default: 0};
        m[0] = 7; v[0] = 9;
        run(1, m, v, 0, -1, 0);
        chk("n1_r0", got_d[0], 63);
        chk("n1_l0", got_l[0], 1);

        for (int k = 0; k < 2; k++) begin
            start = 1;
            cfg_n = (k == 0) ? 4'd0 : 4'd9;
            tick();
            start = 0;
            chk("err_pulse", err, 1);
            chk("err_busy", busy, 0);
            chk("err_in_ready", in_ready, 0);
            tick();
            chk("err_clear", err, 0);
            chk("err_busy2", busy, 0);
        end

        m = '{default: 0};
        v = '{default: 0};
        for (int i = 0; i < 9; i++) m[i] = i + 1;
        v[0] = 1; v[1] = 2; v[2] = 3;
        run(3, m, v, 1, 1, 1);
        chk("n3_r0", got_d[0], 14);
        chk("n3_r1", got_d[1], 32);
        chk("n3_r2", got_d[2], 50);

        start = 1;
        cfg_n = 3;
        tick();
        start = 0;
        for (int i = 0; i < 4; i++) send(i + 1);
        rst = 1;
        tick();
        rst = 0;
        chk_reset_outputs("midreset");
        tick();
        run_n2();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule

// File: doc/mxv_stream_engine.md
# mxv_stream_engine

Parametrised matrix-by-vector multiply engine, the next generation of the MxV datapath. It accepts a square matrix of run-time size N (1..MAX_N) and an N-element vector over a ready/valid byte stream, then emits the N dot-product results over a ready/valid output stream with backpressure. It sits between the UART receive PIPO and the transmit path. It replaces the fixed eight-RAM fan-out with one parametrised storage array and a single MAC.

## Interface
- DW, 8: element width in bits, unsigned.
- MAX_N, 8: maximum matrix dimension, ≥1.
- NW, $clog2(MAX_N+1): width of the size field.
- ACC_W, 2*DW+$clog2(MAX_N): result width. With the defaults this is 19, and an all-ones 8×8 input cannot overflow.

- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a run; sampled only in IDLE.
- cfg_n  in  NW  matrix size, latched on an accepted start.
- in_valid  in  1  input element valid.
- in_data  in  DW  input element.
- in_ready  out  1  engine accepts in_data this cycle.
- out_valid  out  1  result valid.
- out_data  out  ACC_W  dot product of one row.
- out_last  out  1  marks the result of row N-1.
- out_ready  in  1  downstream accepts the result.
- busy  out  1  high in every state except IDLE.
- err  out  1  one-cycle pulse when a start is rejected.

## Operation
- States: IDLE, LOAD_MAT, LOAD_VEC, COMPUTE, EMIT.
- IDLE:
  - start with 1 ≤ cfg_n ≤ MAX_N → latch N, clear the row and column counters, go to LOAD_MAT.
  - start with cfg_n = 0 or cfg_n > MAX_N → err = 1 for the next cycle; state stays IDLE.
- LOAD_MAT:
  - in_ready = 1. Each handshake (in_valid & in_ready) writes M[r][c]; order is row-major.
  - c increments; when c = N-1, c wraps to 0 and r increments.
  - After element (N-1, N-1), go to LOAD_VEC.
- LOAD_VEC:
  - in_ready = 1. Each handshake writes V[c].
  - After element N-1, clear r, c and acc, then go to COMPUTE.
- COMPUTE:
  - in_ready = 0. One MAC per cycle: acc ← acc + M[r][c]·V[c], unsigned, ACC_W bits, no saturation.
  - After c = N-1: out_data ← final sum, out_valid ← 1, out_last ← (r = N-1), go to EMIT.
- EMIT:
  - out_data holds stable while out_valid & !out_ready.
  - On handshake: out_valid ← 0; clear acc and c.
  - If out_last, go to IDLE. Otherwise r ← r+1 and return to COMPUTE.
- start outside IDLE is ignored and does not raise err.
- in_valid outside the load states is ignored.
- Storage contents are not cleared by reset or by a new run. Every location read in a run is written earlier in that same run.

## Timing
- Reset values: in_ready 0, out_valid 0, out_data 0, out_last 0, busy 0, err 0. State IDLE; all counters and acc 0.
- Reset asserted in any state wins over every other event and takes effect at that edge.
- start accepted at edge k → busy and in_ready are 1 from cycle k+1.
- With in_valid held high, N²+N input cycles fill the matrix and vector.
- COMPUTE latency per row is N cycles. out_valid rises on the edge after the last MAC.
- With out_ready held high, a row takes N+1 cycles. Total output time is N·(N+1) cycles.
- out_valid must never drop without a handshake.
- busy falls on the edge of the final output handshake.
- in_ready never depends combinationally on in_valid.
- The out_ready → state path may be combinational; in_ready and out_valid are registered.

## Structure
- Definitions_Package gains:
  - MXV_DW and MXV_MAX_N as defaults.
  - typedef enum mxv_state_t {IDLE, LOAD_MAT, LOAD_VEC, COMPUTE, EMIT}.
- Sub-module mxv_mat_ram: single-clock, MAX_N·MAX_N × DW, synchronous write, address r·MAX_N+c.
  - Read is asynchronous or a one-cycle registered read.
  - A registered read adds one pipeline stage to COMPUTE; the cycle counts above are then +1 per row, and the test plan must be updated to match.
- The vector lives in a MAX_N × DW register file inside the engine.

## Test plan
- N=2, M=[1,2;3,4], V=[5,6], out_ready high → out_data 17 then 39; out_last on 39 only; busy low afterwards.
- N=8, all elements 255 → eight results of 520200; no overflow.
- N=1, M=[7], V=[9] → single result 63 with out_last = 1.
- start with cfg_n = 0, then with cfg_n = 9 → err pulses one cycle each, busy stays 0. A start during LOAD_MAT is ignored.
- N=3 with out_ready low for 4 cycles on row 1, and in_valid gapped during load → out_data holds stable while stalled; results are correct.
- rst pulsed mid-LOAD_MAT → all outputs at reset values next cycle. A fresh N=2 run then yields 17, 39.
